// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory constants, loader state encoding and helpers
package imem_pkg;

    localparam int BYTES_PER_INSTR = 4;
    localparam int IMEM_ADDR_W     = 64;
    localparam int IMEM_SIZE       = 4095;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_ENC  = 3'd1;
    localparam logic [STATE_W-1:0] ST_PAD_ENC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DONE_ENC  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR_ENC = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_LOAD  = ST_LOAD_ENC,
        ST_PAD   = ST_PAD_ENC,
        ST_DONE  = ST_DONE_ENC,
        ST_ERROR = ST_ERROR_ENC
    } loader_state_t;

    // True when a byte offset (relative to the image base) starts a new instruction word
    function automatic logic is_aligned(input logic [IMEM_ADDR_W-1:0] offset);
        return (offset % IMEM_ADDR_W'(BYTES_PER_INSTR)) == '0;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - program byte stream in, imem byte write port out
interface imem_loader_if;
    import imem_pkg::*;

    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_last;
    logic                   byte_ready;
    logic                   wr_en;
    logic [IMEM_ADDR_W-1:0] wr_addr;
    logic [7:0]             wr_data;

    // Stream source / memory side
    modport master (
        output byte_in, byte_valid, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    // Loader side
    modport slave (
        input  byte_in, byte_valid, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program image into imem, zero-pads to a word boundary, holds the core
module imem_loader
    import imem_pkg::*;
#(
    parameter int                     MEM_SIZE  = IMEM_SIZE,
    parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    imem_loader_if.slave           bus,
    output logic                   core_hold,
    output logic                   done,
    output logic                   error,
    output logic [IMEM_ADDR_W-1:0] byte_count,
    output logic [7:0]             checksum
);

    localparam logic [IMEM_ADDR_W-1:0] MEM_LIMIT = IMEM_ADDR_W'(MEM_SIZE);

    loader_state_t          state;
    loader_state_t          state_nxt;
    logic [IMEM_ADDR_W-1:0] pad_ptr;
    logic [IMEM_ADDR_W-1:0] count_inc;
    logic [IMEM_ADDR_W-1:0] pad_inc;
    logic                   hs;
    logic                   room;
    logic                   fin_load;
    logic                   fin_pad;

    assign hs        = bus.byte_valid & bus.byte_ready;
    assign room      = byte_count < MEM_LIMIT;
    assign count_inc = byte_count + 1'b1;
    assign pad_inc   = pad_ptr + 1'b1;
    // Image is complete once the next free offset is word aligned or memory is full
    assign fin_load  = is_aligned(count_inc) || (count_inc == MEM_LIMIT);
    assign fin_pad   = is_aligned(pad_inc) || (pad_inc == MEM_LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision: start only honoured outside an active load
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (hs) begin
                    if (!room)                          state_nxt = ST_ERROR;
                    else if (bus.byte_last && fin_load) state_nxt = ST_DONE;
                    else if (bus.byte_last)             state_nxt = ST_PAD;
                end
            end
            ST_PAD:  if (fin_pad) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        bus.byte_ready = (state == ST_LOAD);
        core_hold      = (state != ST_DONE);
        done           = (state == ST_DONE);
        error          = (state == ST_ERROR);
    end

    // Registered write port, byte counter, checksum and pad pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            byte_count  <= '0;
            checksum    <= '0;
            pad_ptr     <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        byte_count <= '0;
                        checksum   <= '0;
                    end
                end
                ST_LOAD: begin
                    // A byte arriving with no room is dropped: no write, no count
                    if (hs && room) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= BASE_ADDR + byte_count;
                        bus.wr_data <= bus.byte_in;
                        byte_count  <= count_inc;
                        checksum    <= checksum + bus.byte_in;
                        pad_ptr     <= count_inc;
                    end
                end
                ST_PAD: begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= BASE_ADDR + pad_ptr;
                    bus.wr_data <= 8'h00;
                    pad_ptr     <= pad_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized bench for imem_loader against a queue-based image model
module tb_imem_loader;
    import imem_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if bus_big();
    imem_loader_if bus_small();

    assign bus_big.byte_in      = byte_in;
    assign bus_big.byte_valid   = byte_valid;
    assign bus_big.byte_last    = byte_last;
    assign bus_small.byte_in    = byte_in;
    assign bus_small.byte_valid = byte_valid;
    assign bus_small.byte_last  = byte_last;

    logic        hold_b, done_b, err_b, hold_s, done_s, err_s;
    logic [63:0] cnt_b, cnt_s;
    logic [7:0]  sum_b, sum_s;

    imem_loader #(.MEM_SIZE(4095), .BASE_ADDR(64'h0)) u_big (
        .clk(clk), .reset(reset), .start(start & ~sel), .bus(bus_big.slave),
        .core_hold(hold_b), .done(done_b), .error(err_b),
        .byte_count(cnt_b), .checksum(sum_b)
    );

    imem_loader #(.MEM_SIZE(8), .BASE_ADDR(64'h100)) u_small (
        .clk(clk), .reset(reset), .start(start & sel), .bus(bus_small.slave),
        .core_hold(hold_s), .done(done_s), .error(err_s),
        .byte_count(cnt_s), .checksum(sum_s)
    );

    logic        o_ready, o_wr_en, o_hold, o_done, o_err;
    logic [63:0] o_addr, o_count;
    logic [7:0]  o_data, o_sum;

    assign o_ready = sel ? bus_small.byte_ready : bus_big.byte_ready;
    assign o_wr_en = sel ? bus_small.wr_en      : bus_big.wr_en;
    assign o_addr  = sel ? bus_small.wr_addr    : bus_big.wr_addr;
    assign o_data  = sel ? bus_small.wr_data    : bus_big.wr_data;
    assign o_hold  = sel ? hold_s : hold_b;
    assign o_done  = sel ? done_s : done_b;
    assign o_err   = sel ? err_s  : err_b;
    assign o_count = sel ? cnt_s  : cnt_b;
    assign o_sum   = sel ? sum_s  : sum_b;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        bit          pad;
    } wr_t;

    wr_t exp_q[$];
    int  hs_q[$];
    int  cyc = 0;

    int       m_count = 0;
    bit [7:0] m_sum = 0;
    bit       m_err = 0;
    bit       m_loading = 0;

    function automatic int cur_ms();
        return sel ? 8 : 4095;
    endfunction

    function automatic logic [63:0] cur_base();
        return sel ? 64'h100 : 64'h0;
    endfunction

    always @(posedge clk) cyc++;

    // Write-port monitor: each write must match the next expected image byte
    wr_t e;
    always @(negedge clk) begin
        if (byte_valid === 1'b1 && o_ready === 1'b1) hs_q.push_back(cyc);
        if (o_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("extra_wr", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", o_addr, e.addr);
                chk("wr_data", {56'h0, o_data}, {56'h0, e.data});
                if (!e.pad) begin
                    if (hs_q.size() == 0) chk("wr_no_hs", 1, 0);
                    else chk("wr_lat", 64'(cyc - hs_q.pop_front()), 1);
                end
            end
        end
    end

    // Model: a byte taken at offset n lands at base+n; a finished image is zero-filled to 4 bytes
    task automatic mdl_accept(input logic [7:0] b, input bit last);
        wr_t w;
        int  p;
        if (m_count < cur_ms()) begin
            w.addr = cur_base() + 64'(m_count); w.data = b; w.pad = 1'b0;
            exp_q.push_back(w);
            m_count++;
            m_sum += b;
            if (last) begin
                m_loading = 0;
                p = m_count;
                while ((p % 4) != 0 && p < cur_ms()) begin
                    w.addr = cur_base() + 64'(p); w.data = 8'h00; w.pad = 1'b1;
                    exp_q.push_back(w);
                    p++;
                end
            end
        end else begin
            m_err = 1;
            m_loading = 0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        if (!m_loading) begin
            m_loading = 1; m_count = 0; m_sum = 0; m_err = 0;
            hs_q.delete();
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            byte_valid = 1'b0;
            byte_last = 1'($urandom);
            byte_in = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_last = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        bit acc = 0;
        byte_in = b; byte_valid = 1'b1; byte_last = last;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                mdl_accept(b, last);
                acc = 1;
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; byte_last = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic finish_checks(input string tag);
        bit seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_err === 1'b1) seen = 1;
        end
        if (!seen) chk({tag, "_end_timeout"}, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_count"}, o_count, 64'(m_count));
        chk({tag, "_sum"}, {56'h0, o_sum}, {56'h0, m_sum});
        chk({tag, "_done"}, o_done, !m_err);
        chk({tag, "_error"}, o_err, m_err);
        chk({tag, "_hold"}, o_hold, m_err);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_data", {56'h0, o_data}, 0);
        chk("rst_hold", o_hold, 1);
        chk("rst_done", o_done, 0);
        chk("rst_error", o_err, 0);
        chk("rst_count", o_count, 0);
        chk("rst_sum", {56'h0, o_sum}, 0);
        m_loading = 0; m_count = 0; m_sum = 0; m_err = 0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog2 [5];
        int n;
        prog2 = '{8'h13, 8'h00, 8'h00, 8'h93, 8'hAA};

        do_reset();
        idle(2);
        // stream without start is never accepted
        byte_valid = 1'b1; byte_in = 8'h55;
        @(negedge clk);
        chk("idle_ready", o_ready, 0);
        @(posedge clk); #1;
        byte_valid = 1'b0;

        // bytes 00..07, aligned, no pad
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'(i), i == 7);
        finish_checks("t1");
        chk("t1_sum_const", {56'h0, o_sum}, 64'h1C);

        // restart from DONE, then 5 bytes needing 3 pads
        pulse_start();
        @(negedge clk);
        chk("t6_done_drop", o_done, 0);
        chk("t6_hold", o_hold, 1);
        chk("t6_sum_clr", {56'h0, o_sum}, 0);
        chk("t6_cnt_clr", o_count, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send(prog2[i], i == 4);
        finish_checks("t2");
        chk("t2_sum_const", {56'h0, o_sum}, 64'h50);
        chk("t2_cnt_const", o_count, 64'd5);

        // valid pattern 1,0,0,1,1,0,1
        pulse_start();
        send(8'($urandom), 0); idle(2);
        send(8'($urandom), 0); send(8'($urandom), 0); idle(1);
        send(8'($urandom), 1);
        finish_checks("t3");

        // start pulsed mid-load must not restart the count
        pulse_start();
        send(8'hA1, 0); send(8'hB2, 0);
        pulse_start();
        send(8'hC3, 0); send(8'hD4, 0); send(8'hE5, 1);
        finish_checks("t6b");
        chk("t6b_cnt_const", o_count, 64'd5);

        // random images with random gaps
        for (int r = 0; r < 8; r++) begin
            pulse_start();
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom), i == n - 1);
            end
            finish_checks("rnd");
        end

        // reset mid-load: partial writes kept, nothing after, restart from base
        pulse_start();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        do_reset();
        idle(4);
        chk("t5_pending", exp_q.size(), 0);
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'($urandom), i == 3);
        finish_checks("t5");

        // small memory: overflow, recovery, pad capped by alignment, exact fill
        sel = 1'b1;
        idle(1);
        pulse_start();
        for (int i = 0; i < 9; i++) send(8'($urandom), 0);
        finish_checks("t4");
        chk("t4_err_const", o_err, 1);
        pulse_start();
        @(negedge clk);
        chk("t4_err_clr", o_err, 0);
        chk("t4_cnt_clr", o_count, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(8'($urandom), i == 5);
        finish_checks("t4b");
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'($urandom), i == 7);
        finish_checks("t4c");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
